// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave oven controller.
// Digits are plain BCD nibbles and segment patterns are ordered {g,f,e,d,c,b,a}.
package microwave_pkg;

    localparam int KEY_W = 10;

    typedef logic [3:0] bcd_t;

    typedef enum logic {
        IDLE,
        COOKING
    } state_t;

    localparam logic [6:0] SEG_0 = 7'b0111111;
    localparam logic [6:0] SEG_1 = 7'b0000110;
    localparam logic [6:0] SEG_2 = 7'b1011011;
    localparam logic [6:0] SEG_3 = 7'b1001111;
    localparam logic [6:0] SEG_4 = 7'b1100110;
    localparam logic [6:0] SEG_5 = 7'b1101101;
    localparam logic [6:0] SEG_6 = 7'b1111101;
    localparam logic [6:0] SEG_7 = 7'b0000111;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1101111;

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational BCD to active-high 7-segment decoder.
// Codes above 9 never reach this block, so they simply blank the digit.
module seven_seg_decoder
    import microwave_pkg::*;
(
    input  bcd_t       i_digit,
    output logic [6:0] o_seg
);

    always_comb begin
        case (i_digit)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = 7'b0000000;
        endcase
    end

endmodule

// File: rtl/microwave.sv
// Microwave oven controller: keypad time entry, M:SS countdown driven by an
// internal 1 s prescaler, magnetron enable and three 7-segment digits.
module microwave
    import microwave_pkg::*;
#(
    parameter int CLK_HZ = 100
)
(
    input  logic             clock,
    input  logic             reset,
    input  logic             startn,
    input  logic             stopn,
    input  logic             clearn,
    input  logic             door_closed,
    input  logic [KEY_W-1:0] keys,
    output logic             mag_on,
    output logic [6:0]       ssec_ones,
    output logic [6:0]       ssec_tens,
    output logic [6:0]       smin
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    logic             r_startn;
    logic             r_stopn;
    logic             r_clearn;
    logic             r_door;
    logic [KEY_W-1:0] r_keys;
    logic             r_keyPrev;

    state_t           r_state;
    logic             r_magOn;
    logic [PW-1:0]    r_presc;
    bcd_t             r_min;
    bcd_t             r_tens;
    bcd_t             r_ones;

    bcd_t             w_keyDigit;
    logic             w_keyPress;
    logic             w_tick;
    logic             w_timeZero;
    logic             w_nextZero;
    bcd_t             w_nextMin;
    bcd_t             w_nextTens;
    bcd_t             w_nextOnes;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_startn  <= 1'b1;
            r_stopn   <= 1'b1;
            r_clearn  <= 1'b1;
            r_door    <= 1'b0;
            r_keys    <= '0;
            r_keyPrev <= 1'b0;
        end else begin
            r_startn  <= startn;
            r_stopn   <= stopn;
            r_clearn  <= clearn;
            r_door    <= door_closed;
            r_keys    <= keys;
            r_keyPrev <= |r_keys;
        end
    end

    // Descending scan so the lowest set key bit overwrites the others.
    always_comb begin
        w_keyDigit = '0;
        for (int k = KEY_W - 1; k >= 0; k--) begin
            if (r_keys[k]) begin
                w_keyDigit = bcd_t'(k);
            end
        end
    end

    assign w_keyPress = (|r_keys) & ~r_keyPrev;
    assign w_tick     = (r_presc == PW'(CLK_HZ - 1));
    assign w_timeZero = (r_min == 4'd0) && (r_tens == 4'd0) && (r_ones == 4'd0);

    always_comb begin
        w_nextMin  = r_min;
        w_nextTens = r_tens;
        w_nextOnes = r_ones;
        if (r_ones != 4'd0) begin
            w_nextOnes = r_ones - 4'd1;
        end else if (r_tens != 4'd0) begin
            w_nextTens = r_tens - 4'd1;
            w_nextOnes = 4'd9;
        end else if (r_min != 4'd0) begin
            w_nextMin  = r_min - 4'd1;
            w_nextTens = 4'd5;
            w_nextOnes = 4'd9;
        end
    end

    assign w_nextZero = (w_nextMin == 4'd0) && (w_nextTens == 4'd0) && (w_nextOnes == 4'd0);

    // Clear beats pause, pause beats start; the prescaler only runs while heating.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_magOn <= 1'b0;
            r_presc <= '0;
            r_min   <= '0;
            r_tens  <= '0;
            r_ones  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_presc <= '0;
                    if (!r_clearn) begin
                        r_min  <= '0;
                        r_tens <= '0;
                        r_ones <= '0;
                    end else begin
                        if (w_keyPress) begin
                            r_min  <= r_tens;
                            r_tens <= r_ones;
                            r_ones <= w_keyDigit;
                        end
                        if (r_stopn && r_door && !r_startn && !w_timeZero) begin
                            r_state <= COOKING;
                            r_magOn <= 1'b1;
                        end
                    end
                end
                COOKING: begin
                    if (!r_clearn) begin
                        r_state <= IDLE;
                        r_magOn <= 1'b0;
                        r_presc <= '0;
                        r_min   <= '0;
                        r_tens  <= '0;
                        r_ones  <= '0;
                    end else if (!r_stopn || !r_door) begin
                        r_state <= IDLE;
                        r_magOn <= 1'b0;
                        r_presc <= '0;
                    end else if (w_tick) begin
                        r_presc <= '0;
                        r_min   <= w_nextMin;
                        r_tens  <= w_nextTens;
                        r_ones  <= w_nextOnes;
                        if (w_nextZero) begin
                            r_state <= IDLE;
                            r_magOn <= 1'b0;
                        end
                    end else begin
                        r_presc <= r_presc + PW'(1);
                    end
                end
            endcase
        end
    end

    assign mag_on = r_magOn;

    seven_seg_decoder u_decOnes (.i_digit(r_ones), .o_seg(ssec_ones));
    seven_seg_decoder u_decTens (.i_digit(r_tens), .o_seg(ssec_tens));
    seven_seg_decoder u_decMin  (.i_digit(r_min),  .o_seg(smin));

endmodule

// File: tb/tb_microwave.sv
// Bench for the microwave controller: the expected display is kept as an integer
// M:SS value (min*100 + tens*10 + ones) and advanced by plain arithmetic.
module tb_microwave;

    logic       clock;
    logic       reset;
    logic       startn;
    logic       stopn;
    logic       clearn;
    logic       door_closed;
    logic [9:0] keys;
    logic       mag_on;
    logic [6:0] ssec_ones;
    logic [6:0] ssec_tens;
    logic [6:0] smin;

    int vectors;
    int miscompares;
    int expTime;
    int phase;

    logic [6:0] segTab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                                7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

    microwave #(.CLK_HZ(100)) dut (
        .clock(clock), .reset(reset), .startn(startn), .stopn(stopn), .clearn(clearn),
        .door_closed(door_closed), .keys(keys), .mag_on(mag_on),
        .ssec_ones(ssec_ones), .ssec_tens(ssec_tens), .smin(smin)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Whole-second step on the M:SS value; xx:00 borrows a minute and becomes :59.
    function automatic int decTime(input int t);
        if (t % 100 == 0) return t - 100 + 59;
        return t - 1;
    endfunction

    function automatic int shiftIn(input int t, input int k);
        return (t * 10 + k) % 1000;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
        phase += n;
    endtask

    task automatic checkOutput(input string tag, input int t, input logic m);
        logic [6:0] eo, et, em;
        eo = segTab[t % 10];
        et = segTab[(t / 10) % 10];
        em = segTab[(t / 100) % 10];
        vectors++;
        assert (ssec_ones === eo) else begin
            miscompares++;
            $error("[TB] FAIL %s ones observed=%b expected=%b", tag, ssec_ones, eo);
        end
        vectors++;
        assert (ssec_tens === et) else begin
            miscompares++;
            $error("[TB] FAIL %s tens observed=%b expected=%b", tag, ssec_tens, et);
        end
        vectors++;
        assert (smin === em) else begin
            miscompares++;
            $error("[TB] FAIL %s min observed=%b expected=%b", tag, smin, em);
        end
        vectors++;
        assert (mag_on === m) else begin
            miscompares++;
            $error("[TB] FAIL %s mag_on observed=%b expected=%b", tag, mag_on, m);
        end
    endtask

    // One key press held for holdCycles (>= 2); the shift must land on the 2nd edge only.
    task automatic applyStimulus(input int k, input int holdCycles);
        keys = 10'd1 << k;
        tick(1);
        checkOutput("keyEarly", expTime, 1'b0);
        tick(1);
        expTime = shiftIn(expTime, k);
        checkOutput("keyLate", expTime, 1'b0);
        tick(holdCycles - 2);
        keys = '0;
        tick(15);
        checkOutput("keyHeld", expTime, 1'b0);
    endtask

    task automatic startCook();
        startn = 1'b0;
        tick(2);
        phase = 0;
        checkOutput("start", expTime, 1'b1);
        tick(3);
        startn = 1'b1;
    endtask

    task automatic runSeconds(input int n);
        tick(100 - phase - 1);
        checkOutput("preTick", expTime, 1'b1);
        for (int i = 0; i < n; i++) begin
            if (i > 0) tick(99);
            tick(1);
            expTime = decTime(expTime);
            checkOutput("tick", expTime, expTime != 0);
        end
        phase = 0;
    endtask

    task automatic clearAll();
        clearn = 1'b0;
        tick(2);
        expTime = 0;
        checkOutput("clear", expTime, 1'b0);
        clearn = 1'b1;
        tick(3);
    endtask

    initial begin
        int k;
        vectors     = 0;
        miscompares = 0;
        phase       = 0;
        expTime     = 0;
        reset       = 1'b1;
        startn      = 1'b1;
        stopn       = 1'b1;
        clearn      = 1'b1;
        door_closed = 1'b1;
        keys        = '0;
        tick(3);
        checkOutput("resetHeld", 0, 1'b0);
        reset = 1'b0;
        tick(2);
        checkOutput("resetOut", 0, 1'b0);

        foreach (segTab[i]) begin
            if (i < 8) applyStimulus((i < 6) ? 1 : ((i == 6) ? 2 : 8), 5);
        end
        checkOutput("enter128", 128, 1'b0);

        startCook();
        runSeconds(1);
        checkOutput("at127", 127, 1'b1);
        runSeconds(27);
        checkOutput("at100", 100, 1'b1);
        runSeconds(1);
        checkOutput("at059", 59, 1'b1);
        clearAll();

        applyStimulus(3, 5);
        startCook();
        runSeconds(3);
        checkOutput("doneZero", 0, 1'b0);
        startn = 1'b0;
        tick(5);
        startn = 1'b1;
        tick(3);
        checkOutput("startAtZero", 0, 1'b0);

        for (int r = 0; r < 3; r++) begin
            clearAll();
            applyStimulus(int'($urandom_range(1, 9)), int'($urandom_range(2, 20)));
            applyStimulus(int'($urandom_range(0, 9)), int'($urandom_range(2, 20)));
            applyStimulus(int'($urandom_range(0, 9)), int'($urandom_range(2, 20)));
            startCook();
            runSeconds(int'($urandom_range(1, 3)));
            tick(int'($urandom_range(10, 60)));
            door_closed = 1'b0;
            tick(2);
            checkOutput("doorOpen", expTime, 1'b0);
            tick(250);
            checkOutput("doorFrozen", expTime, 1'b0);
            door_closed = 1'b1;
            tick(3);
            startCook();
            runSeconds(2);
            stopn = 1'b0;
            tick(2);
            checkOutput("stopPause", expTime, 1'b0);
            stopn = 1'b1;
            tick(120);
            checkOutput("stopHold", expTime, 1'b0);
        end

        clearAll();
        applyStimulus(5, 5);
        startn = 1'b0;
        stopn  = 1'b0;
        tick(10);
        checkOutput("startStop", 5, 1'b0);
        startn = 1'b1;
        stopn  = 1'b1;
        tick(3);
        startCook();
        runSeconds(1);
        tick(20);
        clearAll();

        applyStimulus(4, 5);
        applyStimulus(7, 5);
        startCook();
        tick(10);
        k = int'($urandom_range(0, 9));
        keys = 10'd1 << k;
        tick(5);
        keys = '0;
        tick(5);
        checkOutput("keyWhileCook", expTime, 1'b1);
        stopn = 1'b0;
        tick(2);
        checkOutput("stopForKey", expTime, 1'b0);
        stopn = 1'b1;
        tick(3);
        keys = 10'b0000100100;
        tick(2);
        expTime = shiftIn(expTime, 2);
        checkOutput("multiKey", expTime, 1'b0);
        keys = '0;
        tick(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
